// File: rtl/bus_arb4x32.sv
// Four-requester round-robin bus arbiter with a shared, registered 32-bit data path.
// A grantee may stream up to BURST words back-to-back before the pointer rotates
// past it. Every output is a flop, so no input reaches an output combinationally.
module bus_arb4x32 #(
  parameter int unsigned BURST = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [3:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic        ready,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [31:0] y,
  output logic        valid
);

  localparam logic [3:0] BurstMax = 4'(BURST);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state;
  logic [1:0]  ptr;
  logic [3:0]  beat;

  logic [1:0]  arb_base;
  logic        arb_found;
  logic [1:0]  arb_idx;
  logic [1:0]  cand;
  logic [31:0] arb_data;
  logic [31:0] cur_data;
  logic        xfer;
  logic        keep_burst;

  // Search origin: the stored pointer when idle, one past the grantee when a burst ends.
  // Using sel+1 here lets the rotation and the re-arbitration happen in the same edge.
  always_comb begin
    arb_base = (state == StBusy) ? sel + 2'd1 : ptr;
  end

  // Round-robin winner: scan from the far end so the first hit in search order wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = arb_base;
    cand      = arb_base;
    for (int k = 3; k >= 0; k--) begin
      cand = arb_base + 2'(k);
      if (req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Data word of the arbitration winner.
  always_comb begin
    unique case (arb_idx)
      2'd0:    arb_data = a0;
      2'd1:    arb_data = a1;
      2'd2:    arb_data = a2;
      default: arb_data = a3;
    endcase
  end

  // Data word of the current grantee, used for back-to-back beats.
  always_comb begin
    unique case (sel)
      2'd0:    cur_data = a0;
      2'd1:    cur_data = a1;
      2'd2:    cur_data = a2;
      default: cur_data = a3;
    endcase
  end

  // Transfer qualification and burst-continue decision.
  always_comb begin
    xfer       = valid & ready;
    keep_burst = req[sel] & (beat < BurstMax);
  end

  // Arbiter FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= StIdle;
      valid <= 1'b0;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      y     <= 32'h0;
      ptr   <= 2'd0;
      beat  <= 4'd0;
    end else begin
      case (state)
        StIdle: begin
          if (arb_found) begin
            state <= StBusy;
            valid <= 1'b1;
            sel   <= arb_idx;
            gnt   <= 4'b0001 << arb_idx;
            y     <= arb_data;
            beat  <= 4'd1;
          end
        end
        StBusy: begin
          // Without a transfer everything holds, regardless of req or data inputs.
          if (xfer) begin
            if (keep_burst) begin
              y    <= cur_data;
              beat <= beat + 4'd1;
            end else begin
              ptr <= sel + 2'd1;
              if (arb_found) begin
                sel  <= arb_idx;
                gnt  <= 4'b0001 << arb_idx;
                y    <= arb_data;
                beat <= 4'd1;
              end else begin
                // sel and y are left as they were so the last grantee stays visible.
                state <= StIdle;
                valid <= 1'b0;
                gnt   <= 4'b0000;
                beat  <= 4'd0;
              end
            end
          end
        end
        default: begin
          state <= StIdle;
          valid <= 1'b0;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb4x32.sv
// Scoreboard bench for bus_arb4x32. Three instances (BURST = 4, 1, 2) share the
// request/data/reset inputs; each has its own ready so only the instance under test
// ever transfers. Expected transfers are queued per instance and popped by a monitor.
module tb_bus_arb4x32;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] a0 = 32'h0;
  logic [31:0] a1 = 32'h0;
  logic [31:0] a2 = 32'h0;
  logic [31:0] a3 = 32'h0;
  logic [2:0]  ready_v = 3'b000;

  logic [3:0]  gnt [3];
  logic [1:0]  sel [3];
  logic [31:0] y   [3];
  logic        valid [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] y;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q2[$];

  always #5 clk = ~clk;

  bus_arb4x32 #(.BURST(4)) u_dut_b4 (
    .clk(clk), .clrn(clrn), .req(req), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .ready(ready_v[0]), .gnt(gnt[0]), .sel(sel[0]), .y(y[0]), .valid(valid[0])
  );

  bus_arb4x32 #(.BURST(1)) u_dut_b1 (
    .clk(clk), .clrn(clrn), .req(req), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .ready(ready_v[1]), .gnt(gnt[1]), .sel(sel[1]), .y(y[1]), .valid(valid[1])
  );

  bus_arb4x32 #(.BURST(2)) u_dut_b2 (
    .clk(clk), .clrn(clrn), .req(req), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .ready(ready_v[2]), .gnt(gnt[2]), .sel(sel[2]), .y(y[2]), .valid(valid[2])
  );

  task automatic push(input int d, input logic [1:0] s, input logic [31:0] v);
    exp_t e;
    e.sel = s;
    e.y   = v;
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn    = 1'b0;
    req     = 4'b0000;
    ready_v = 3'b000;
    step();
    step();
    clrn = 1'b1;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid, ready and clrn are high.
  exp_t mon_e;
  logic mon_got;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (clrn && ready_v[d] && valid[d]) begin
        mon_got = 1'b0;
        mon_e   = '0;
        case (d)
          0:       if (exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_got = 1'b1; end
          1:       if (exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_got = 1'b1; end
          default: if (exp_q2.size() > 0) begin mon_e = exp_q2.pop_front(); mon_got = 1'b1; end
        endcase
        checks++;
        if (!mon_got) begin
          errors++;
          $display("FAIL xfer_unexpected dut%0d: got sel=%0d y=%h, required no transfer",
                   d, sel[d], y[d]);
        end else if (sel[d] !== mon_e.sel || y[d] !== mon_e.y ||
                     gnt[d] !== (4'b0001 << mon_e.sel)) begin
          errors++;
          $display("FAIL xfer dut%0d: got sel=%0d gnt=%b y=%h, required sel=%0d gnt=%b y=%h",
                   d, sel[d], gnt[d], y[d], mon_e.sel, 4'b0001 << mon_e.sel, mon_e.y);
        end
      end
    end
  end

  logic [3:0] hold_req [5];

  initial begin
    hold_req[0] = 4'b1111;
    hold_req[1] = 4'b0000;
    hold_req[2] = 4'b1101;
    hold_req[3] = 4'b0001;
    hold_req[4] = 4'b1010;

    // Reset state of all instances.
    do_reset();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'h0);
      check($sformatf("rst_sel%0d", d), 32'(sel[d]), 32'h0);
      check($sformatf("rst_y%0d", d), y[d], 32'h0);
      check($sformatf("rst_valid%0d", d), 32'(valid[d]), 32'h0);
    end

    // Single requester 2, four beats, req dropped for the last one; sel retained in idle.
    do_reset();
    a2 = 32'hCAFE0002;
    req = 4'b0100;
    ready_v = 3'b001;
    for (int i = 0; i < 4; i++) push(0, 2'd2, 32'hCAFE0002);
    step();
    check("s1_gnt", 32'(gnt[0]), 32'h4);
    check("s1_sel", 32'(sel[0]), 32'h2);
    check("s1_valid", 32'(valid[0]), 32'h1);
    check("s1_y", y[0], 32'hCAFE0002);
    step();
    step();
    step();
    req = 4'b0000;
    step();
    ready_v = 3'b000;
    check("s1_end_valid", 32'(valid[0]), 32'h0);
    check("s1_end_gnt", 32'(gnt[0]), 32'h0);
    check("s1_end_sel", 32'(sel[0]), 32'h2);
    check("s1_end_y", y[0], 32'hCAFE0002);

    // BURST=1, all requesting: strict rotation 0,1,2,3,0,... with no idle cycle.
    do_reset();
    a0 = 32'hA0A00000;
    a1 = 32'hA1A10001;
    a2 = 32'hA2A20002;
    a3 = 32'hA3A30003;
    req = 4'b1111;
    ready_v = 3'b010;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0:       push(1, 2'd0, 32'hA0A00000);
        1:       push(1, 2'd1, 32'hA1A10001);
        2:       push(1, 2'd2, 32'hA2A20002);
        default: push(1, 2'd3, 32'hA3A30003);
      endcase
    end
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("s2_valid_%0d", i), 32'(valid[1]), 32'h1);
    end
    ready_v = 3'b000;

    // Grant to 1 held with ready low while a1 and req move; transfer on first ready.
    do_reset();
    a1 = 32'h11110001;
    req = 4'b0010;
    step();
    check("s3_gnt", 32'(gnt[0]), 32'h2);
    check("s3_y", y[0], 32'h11110001);
    for (int i = 0; i < 5; i++) begin
      req = hold_req[i];
      a1  = 32'h55550000 + 32'(i);
      step();
      check($sformatf("s3_hold_y_%0d", i), y[0], 32'h11110001);
      check($sformatf("s3_hold_sel_%0d", i), 32'(sel[0]), 32'h1);
      check($sformatf("s3_hold_gnt_%0d", i), 32'(gnt[0]), 32'h2);
    end
    req = 4'b0000;
    push(0, 2'd1, 32'h11110001);
    ready_v = 3'b001;
    step();
    ready_v = 3'b000;
    check("s3_idle_valid", 32'(valid[0]), 32'h0);
    check("s3_idle_gnt", 32'(gnt[0]), 32'h0);

    // BURST=2, ptr moved to 1, req=1001: 3,3,0,0,3,3.
    do_reset();
    a0 = 32'hD0D00000;
    a3 = 32'hD3D30003;
    req = 4'b0001;
    ready_v = 3'b100;
    push(2, 2'd0, 32'hD0D00000);
    push(2, 2'd3, 32'hD3D30003);
    push(2, 2'd3, 32'hD3D30003);
    push(2, 2'd0, 32'hD0D00000);
    push(2, 2'd0, 32'hD0D00000);
    push(2, 2'd3, 32'hD3D30003);
    push(2, 2'd3, 32'hD3D30003);
    step();
    req = 4'b0000;
    step();
    check("s4_idle_valid", 32'(valid[2]), 32'h0);
    req = 4'b1001;
    step();
    check("s4_first_sel", 32'(sel[2]), 32'h3);
    check("s4_first_gnt", 32'(gnt[2]), 32'h8);
    for (int i = 0; i < 6; i++) step();
    ready_v = 3'b000;
    check("s4_regrant_sel", 32'(sel[2]), 32'h0);

    // Reset mid-burst discards the pending word and restarts arbitration from ptr 0.
    do_reset();
    a1 = 32'hE1E10001;
    req = 4'b0010;
    ready_v = 3'b001;
    push(0, 2'd1, 32'hE1E10001);
    step();
    req = 4'b0000;
    step();
    check("s5_idle_valid", 32'(valid[0]), 32'h0);
    a0 = 32'hE0E00000;
    req = 4'b0001;
    push(0, 2'd0, 32'hE0E00000);
    step();
    check("s5_grant0_sel", 32'(sel[0]), 32'h0);
    a0 = 32'hB0B00000;
    step();
    check("s5_beat2_y", y[0], 32'hB0B00000);
    check("s5_beat2_valid", 32'(valid[0]), 32'h1);
    clrn = 1'b0;
    req  = 4'b1010;
    step();
    check("s5_rst_valid", 32'(valid[0]), 32'h0);
    check("s5_rst_gnt", 32'(gnt[0]), 32'h0);
    check("s5_rst_y", y[0], 32'h0);
    clrn = 1'b1;
    ready_v = 3'b000;
    step();
    check("s5_after_sel", 32'(sel[0]), 32'h1);
    check("s5_after_gnt", 32'(gnt[0]), 32'h2);
    check("s5_after_y", y[0], 32'hE1E10001);

    // BURST=4 limit with two requesters: 0 x4, 2 x4, then back to 0.
    do_reset();
    a0 = 32'hF0F00000;
    a2 = 32'hF2F20002;
    req = 4'b0101;
    ready_v = 3'b001;
    for (int i = 0; i < 4; i++) push(0, 2'd0, 32'hF0F00000);
    for (int i = 0; i < 4; i++) push(0, 2'd2, 32'hF2F20002);
    step();
    for (int i = 0; i < 8; i++) step();
    ready_v = 3'b000;
    check("s6_regrant_sel", 32'(sel[0]), 32'h0);
    check("s6_regrant_gnt", 32'(gnt[0]), 32'h1);

    req = 4'b0000;
    repeat (3) step();
    check("q0_empty", 32'(exp_q0.size()), 32'h0);
    check("q1_empty", 32'(exp_q1.size()), 32'h0);
    check("q2_empty", 32'(exp_q2.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
